// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bit positions and
// the access FSM state encoding.
package mem_stage_pkg;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int M_MEMREAD   = 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_wait_timer.sv
// Wait-cycle counter for outstanding data-memory accesses; expired rises
// once TIMEOUT-1 stalled cycles have elapsed for the current access.
module mem_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Counts consecutive stalled cycles; cleared whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count >= LIMIT);

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory req/ack access with stall and timeout abort,
// plus the MEM/WB pipeline register. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_wb,
  input  logic [1:0]  mem_m,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  mem_rd,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        bus_err,
  output logic [1:0]  wb_ctrl,
  output logic [31:0] wb_rdata,
  output logic [31:0] wb_alu_out,
  output logic [4:0]  wb_rd
);

  state_t state;
  logic   access;
  logic   misalign;
  logic   expired;
  logic   abort;
  logic   rd_acked;

  assign access = mem_m[M_MEMWRITE] | mem_m[M_MEMREAD];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (state == IDLE) & access & (mem_alu_out[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Upstream is frozen while stalled, so the bus fields are plain pass-throughs.
  assign dm_req   = (state == WAIT) | (access & ~misalign);
  assign dm_we    = mem_m[M_MEMWRITE];
  assign dm_addr  = mem_alu_out;
  assign dm_wdata = mem_wdata;

  assign abort    = (state == WAIT) & ~dm_ack & expired;
  assign stall    = dm_req & ~dm_ack & ~abort;
  assign bus_err  = abort | misalign;
  assign rd_acked = dm_req & dm_ack & ~mem_m[M_MEMWRITE];

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~stall),
    .en      (stall),
    .expired (expired)
  );

  // Access FSM: any stalled cycle leaves us waiting, otherwise back to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= stall ? WAIT : IDLE;
        WAIT:    state <= stall ? WAIT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, squash write-back on any bus error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ctrl    <= 2'b00;
      wb_rdata   <= 32'h0000_0000;
      wb_alu_out <= 32'h0000_0000;
      wb_rd      <= 5'd0;
    end else if (stall) begin
      wb_ctrl <= 2'b00;
    end else begin
      wb_ctrl    <= bus_err ? 2'b00 : mem_wb;
      wb_alu_out <= mem_alu_out;
      wb_rd      <= mem_rd;
      if (rd_acked) begin
        wb_rdata <= dm_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level
// model, with directed scenarios pinned by hand-computed values.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_wb;
  logic [1:0]  mem_m;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_rd;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        bus_err;
  logic [1:0]  wb_ctrl;
  logic [31:0] wb_rdata;
  logic [31:0] wb_alu_out;
  logic [4:0]  wb_rd;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mem_wb(mem_wb), .mem_m(mem_m),
    .mem_alu_out(mem_alu_out), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall), .bus_err(bus_err),
    .wb_ctrl(wb_ctrl), .wb_rdata(wb_rdata), .wb_alu_out(wb_alu_out), .wb_rd(wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive requests
  logic        d_rst, d_ack, d_snap, d_pin_req;
  logic [1:0]  d_wb, d_m;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [4:0]  d_rd;
  int          d_pin_first, d_pin_last;

  // model: architectural MEM/WB contents plus outstanding-access bookkeeping
  logic [1:0]  m_wb_ctrl, n_wb_ctrl;
  logic [31:0] m_wb_rdata, n_rdata, m_wb_alu_out, n_alu;
  logic [4:0]  m_wb_rd, n_rd;
  logic        m_busy, n_busy, n_valid;
  int          m_waited, n_waited;
  logic        e_valid, e_req, e_stall, e_berr, e_we;
  logic [31:0] e_addr, e_wdata;

  logic chk_en, pin_req;
  int   pin_first, pin_last;
  int   n_checks, n_errors;
  int   dut_stall_cnt, dut_berr_cnt, dut_req_cnt;
  int   base_stall, base_berr, base_req;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Single compare process: pinned literals, then model-vs-DUT on every cycle.
  always @(negedge clk) begin
    string pn;
    logic [31:0] pa, pe;
    if (chk_en) begin
      if (pin_req) begin
        for (int i = pin_first; i <= pin_last; i++) begin
          case (i)
            1, 15: begin pn = (i == 1) ? "rst_wb_zero" : "rst_wait_wb_zero";
                     pa = wb_rdata | wb_alu_out | {25'd0, wb_rd, wb_ctrl}; pe = 32'h0; end
            2:  begin pn = "ld_rdata";      pa = wb_rdata;                 pe = 32'hDEADBEEF; end
            3:  begin pn = "ld_ctrl";       pa = {30'd0, wb_ctrl};         pe = 32'd3; end
            4:  begin pn = "ld_stalls";     pa = dut_stall_cnt - base_stall; pe = 32'd0; end
            5:  begin pn = "model_rdata";   pa = m_wb_rdata;               pe = 32'hDEADBEEF; end
            6:  begin pn = "st_stalls";     pa = dut_stall_cnt - base_stall; pe = 32'd3; end
            7:  begin pn = "st_ctrl";       pa = {30'd0, wb_ctrl};         pe = 32'd1; end
            8:  begin pn = "st_alu";        pa = wb_alu_out;               pe = 32'h20; end
            9:  begin pn = "to_stalls";     pa = dut_stall_cnt - base_stall; pe = 32'd3; end
            10: begin pn = "to_berr";       pa = dut_berr_cnt - base_berr; pe = 32'd1; end
            11: begin pn = "to_ctrl";       pa = {30'd0, wb_ctrl};         pe = 32'd0; end
            12: begin pn = "to_rdata_hold"; pa = wb_rdata;                 pe = 32'hDEADBEEF; end
            13: begin pn = "ackto_berr";    pa = dut_berr_cnt - base_berr; pe = 32'd0; end
            14: begin pn = "ackto_rdata";   pa = wb_rdata;                 pe = 32'hCAFEF00D; end
            16: begin pn = "ack_ignored";   pa = wb_rdata;                 pe = 32'h0; end
`ifdef MEM_ALIGN_CHECK_EN
            17: begin pn = "align_reqs";    pa = dut_req_cnt - base_req;   pe = 32'd0; end
            18: begin pn = "align_berr";    pa = dut_berr_cnt - base_berr; pe = 32'd1; end
            19: begin pn = "align_ctrl";    pa = {30'd0, wb_ctrl};         pe = 32'd0; end
`else
            17: begin pn = "align_reqs";    pa = dut_req_cnt - base_req;   pe = 32'd1; end
            18: begin pn = "align_berr";    pa = dut_berr_cnt - base_berr; pe = 32'd0; end
            19: begin pn = "align_ctrl";    pa = {30'd0, wb_ctrl};         pe = 32'd3; end
`endif
            default: begin pn = "bad_pin"; pa = 32'd1; pe = 32'd0; end
          endcase
          chk(pn, pa, pe);
        end
      end
      chk("wb_ctrl", {30'd0, wb_ctrl}, {30'd0, m_wb_ctrl});
      chk("wb_rdata", wb_rdata, m_wb_rdata);
      chk("wb_alu_out", wb_alu_out, m_wb_alu_out);
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
      if (e_valid) begin
        chk("dm_req", {31'd0, dm_req}, {31'd0, e_req});
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("bus_err", {31'd0, bus_err}, {31'd0, e_berr});
        if (e_req) begin
          chk("dm_addr", dm_addr, e_addr);
          chk("dm_we", {31'd0, dm_we}, {31'd0, e_we});
          chk("dm_wdata", dm_wdata, e_wdata);
        end
        if (stall === 1'b1) dut_stall_cnt++;
        if (bus_err === 1'b1) dut_berr_cnt++;
        if (dm_req === 1'b1) dut_req_cnt++;
      end
    end
  end

  // One clock: commit model, apply inputs, predict this cycle's outputs.
  task automatic cycle();
    logic acc, mis;
    @(posedge clk);
    if (n_valid) begin
      m_wb_ctrl = n_wb_ctrl; m_wb_rdata = n_rdata; m_wb_alu_out = n_alu;
      m_wb_rd = n_rd; m_busy = n_busy; m_waited = n_waited; chk_en = 1'b1;
    end
    if (d_snap) begin
      base_stall = dut_stall_cnt; base_berr = dut_berr_cnt; base_req = dut_req_cnt;
    end
    #1;
    reset = d_rst; mem_wb = d_wb; mem_m = d_m; mem_alu_out = d_addr;
    mem_wdata = d_wdata; mem_rd = d_rd; dm_ack = d_ack; dm_rdata = d_rdata;
    pin_req = d_pin_req; pin_first = d_pin_first; pin_last = d_pin_last;
    acc = (d_m != 2'b00);
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc && !m_busy && (d_addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    e_addr = d_addr; e_we = d_m[0]; e_wdata = d_wdata;
    e_stall = 1'b0; e_berr = 1'b0; e_req = 1'b0; n_valid = 1'b1;
    if (d_rst) begin
      e_valid = 1'b0; n_wb_ctrl = 2'b00; n_rdata = 32'h0; n_alu = 32'h0;
      n_rd = 5'd0; n_busy = 1'b0; n_waited = 0;
    end else begin
      e_valid = 1'b1;
      n_wb_ctrl = d_wb; n_rdata = m_wb_rdata; n_alu = d_addr; n_rd = d_rd;
      n_busy = 1'b0; n_waited = 0;
      e_req = m_busy || (acc && !mis);
      if (!e_req) begin
        e_berr = mis;
        if (mis) n_wb_ctrl = 2'b00;
      end else if (d_ack) begin
        if (!d_m[0]) n_rdata = d_rdata;
      end else if (m_busy && (m_waited + 1 >= TIMEOUT)) begin
        // this is the TIMEOUT-th cycle the access has been outstanding
        e_berr = 1'b1; n_wb_ctrl = 2'b00;
      end else begin
        e_stall = 1'b1; n_wb_ctrl = 2'b00; n_alu = m_wb_alu_out; n_rd = m_wb_rd;
        n_busy = 1'b1; n_waited = m_waited + 1;
      end
    end
  endtask

  task automatic run_access(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd, input int ack_at,
                            input logic [31:0] rdata);
    int k;
    k = 0;
    d_wb = wb; d_m = m; d_addr = addr; d_wdata = wdata; d_rd = rd; d_rst = 1'b0; d_snap = 1'b1;
    do begin
      d_ack = (k == ack_at);
      d_rdata = (k == ack_at) ? rdata : $urandom();
      cycle();
      d_snap = 1'b0;
      k++;
    end while (e_stall && k < TIMEOUT + 4);
  endtask

  task automatic idle(input int pf, input int pl, input logic ack);
    d_m = 2'b00; d_wb = 2'b00; d_rst = 1'b0; d_ack = ack; d_rdata = $urandom();
    d_addr = $urandom(); d_rd = 5'($urandom_range(0, 31));
    d_pin_req = (pf > 0); d_pin_first = pf; d_pin_last = pl;
    cycle();
    d_pin_req = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; chk_en = 1'b0; pin_req = 1'b0; pin_first = 0; pin_last = 0;
    dut_stall_cnt = 0; dut_berr_cnt = 0; dut_req_cnt = 0;
    base_stall = 0; base_berr = 0; base_req = 0;
    n_valid = 1'b0; e_valid = 1'b0; m_busy = 1'b0; m_waited = 0;
    reset = 1'b1; mem_wb = 2'b00; mem_m = 2'b00; mem_alu_out = 32'h0; mem_wdata = 32'h0;
    mem_rd = 5'd0; dm_ack = 1'b0; dm_rdata = 32'h0;
    d_rst = 1'b1; d_ack = 1'b0; d_snap = 1'b0; d_pin_req = 1'b0; d_pin_first = 0; d_pin_last = 0;
    d_wb = 2'b00; d_m = 2'b00; d_addr = 32'h0; d_wdata = 32'h0; d_rdata = 32'h0; d_rd = 5'd0;

    cycle(); cycle();
    idle(1, 1, 1'b0);
    // load acked in the request cycle
    run_access(2'b11, 2'b10, 32'h10, 32'h0, 5'd5, 0, 32'hDEADBEEF);
    idle(2, 5, 1'b0);
    // store acked after three stalled cycles
    run_access(2'b01, 2'b01, 32'h20, 32'h12345678, 5'd6, 3, 32'h0);
    idle(6, 8, 1'b0);
    // load never acked -> timeout abort
    run_access(2'b11, 2'b10, 32'h30, 32'h0, 5'd7, 99, 32'h0);
    idle(9, 12, 1'b0);
    // ack on the exact timeout cycle
    run_access(2'b11, 2'b10, 32'h40, 32'h0, 5'd8, TIMEOUT - 1, 32'hCAFEF00D);
    idle(13, 14, 1'b0);
    // reset while waiting, then a stray ack
    d_wb = 2'b11; d_m = 2'b10; d_addr = 32'h50; d_rd = 5'd9; d_ack = 1'b0; d_rst = 1'b0;
    cycle(); cycle();
    d_rst = 1'b1; cycle();
    idle(15, 15, 1'b1);
    idle(16, 16, 1'b1);
    // misaligned load
    run_access(2'b11, 2'b10, 32'h13, 32'h0, 5'd10, 0, 32'h55AA55AA);
    idle(17, 19, 1'b0);

    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 4) begin
        idle(0, 0, 1'($urandom_range(0, 1)));
      end else if (r == 4) begin
        d_wb = 2'($urandom_range(0, 3)); d_m = 2'($urandom_range(1, 3));
        d_addr = {$urandom_range(0, 65535), 16'h0}; d_rd = 5'($urandom_range(0, 31));
        d_ack = 1'b0; d_rst = 1'b0;
        for (int j = 0; j < $urandom_range(1, 2); j++) cycle();
        d_rst = 1'b1; cycle();
        d_rst = 1'b0;
      end else begin
        logic [31:0] a;
        a = $urandom();
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        run_access(2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)), a, $urandom(),
                   5'($urandom_range(0, 31)), $urandom_range(0, TIMEOUT + 1), $urandom());
      end
    end
    idle(0, 0, 1'b0);
    idle(0, 0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
